nd_2to1_arb: RTL

Two-requester round-robin arbiter that merges two incoming message channels (`rcv0`, `rcv1`) onto one outgoing channel (`snd0`) through a one-entry buffer. It is the fan-in counterpart of the 1-to-2 routing node: it is placed wherever two node outputs must share one link toward a sink or a downstream node. All channels use the network's four-phase req/ack handshake. An optional ingress redundancy check drops corrupted messages.

---
 rtl/hglobal_pkg.sv | 24 ++
 rtl/nd_2to1_arb_pick.sv | 12 +
 rtl/nd_2to1_arb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hglobal_pkg.sv
// rtl/hglobal_pkg.sv - shared network sizes, arbiter state encoding and redundancy function
package hglobal;

    localparam int NS_DATA_SIZE  = 8;
    localparam int NS_REDUN_SIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IN_REL  = 2'd1,
        ST_OUT_ACK = 2'd2,
        ST_OUT_REL = 2'd3
    } ns_arb_state_t;

    // Bit i folds every data bit whose index is congruent to i modulo the field width.
    function automatic logic [NS_REDUN_SIZE-1:0] ns_calc_redun(input logic [NS_DATA_SIZE-1:0] dat);
        logic [NS_REDUN_SIZE-1:0] r;
        r = '0;
        for (int j = 0; j < NS_DATA_SIZE; j++) begin
            r[j % NS_REDUN_SIZE] = r[j % NS_REDUN_SIZE] ^ dat[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/nd_2to1_arb_pick.sv
// rtl/nd_2to1_arb_pick.sv - nd_rr_pick: combinational two-way priority selector
module nd_rr_pick (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant,
    output logic       valid
);

    assign valid = |req;
    assign grant = (req == 2'b11) ? prio : req[1];

endmodule

// File: rtl/nd_2to1_arb.sv
// rtl/nd_2to1_arb.sv - two-input round-robin four-phase merge node; NS_ARB_REDUN_CHK_EN enables ingress redundancy drop
module nd_2to1_arb
    import hglobal::*;
#(
    parameter int DSZ = NS_DATA_SIZE,
    parameter int RSZ = NS_REDUN_SIZE
) (
    input  logic           i_clk,
    input  logic           reset,
    output logic           ready,
    input  logic           rcv0_req,
    output logic           rcv0_ack,
    input  logic [DSZ-1:0] rcv0_dat,
    input  logic [RSZ-1:0] rcv0_red,
    input  logic           rcv1_req,
    output logic           rcv1_ack,
    input  logic [DSZ-1:0] rcv1_dat,
    input  logic [RSZ-1:0] rcv1_red,
    output logic           snd0_req,
    input  logic           snd0_ack,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic           o_err,
    output logic [DSZ-1:0] o_fst_err_dat,
    output logic           o_last_src
);

    ns_arb_state_t  state, state_nxt;
    logic           sel, sel_nxt;
    logic           prio, prio_nxt;
    logic [DSZ-1:0] dat_nxt;
    logic [RSZ-1:0] red_nxt;
    logic           ack0_nxt, ack1_nxt, sreq_nxt, last_nxt;
    logic [1:0]     rdy_sr;
    logic           pick_grant, pick_valid;
    logic           sel_req;

    nd_rr_pick u_pick (
        .req   ({rcv1_req, rcv0_req}),
        .prio  (prio),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    assign sel_req = sel ? rcv1_req : rcv0_req;
    assign ready   = rdy_sr[1];

`ifdef NS_ARB_REDUN_CHK_EN
    logic           chk_ok;
    logic           err_q;
    logic [DSZ-1:0] fst_q;

    assign chk_ok = (snd0_red == RSZ'(ns_calc_redun(NS_DATA_SIZE'(snd0_dat))));

    // Only the first rejected payload is kept; later drops just keep the flag set.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            fst_q <= '0;
        end else if (state == ST_IN_REL && !sel_req && !chk_ok) begin
            err_q <= 1'b1;
            if (!err_q) fst_q <= snd0_dat;
        end
    end

    assign o_err         = err_q;
    assign o_fst_err_dat = fst_q;
`else
    logic chk_ok;
    assign chk_ok        = 1'b1;
    assign o_err         = 1'b0;
    assign o_fst_err_dat = '0;
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        prio_nxt  = prio;
        dat_nxt   = snd0_dat;
        red_nxt   = snd0_red;
        ack0_nxt  = rcv0_ack;
        ack1_nxt  = rcv1_ack;
        sreq_nxt  = snd0_req;
        last_nxt  = o_last_src;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_nxt   = pick_grant;
                    dat_nxt   = pick_grant ? rcv1_dat : rcv0_dat;
                    red_nxt   = pick_grant ? rcv1_red : rcv0_red;
                    ack0_nxt  = !pick_grant;
                    ack1_nxt  = pick_grant;
                    state_nxt = ST_IN_REL;
                end
            end
            ST_IN_REL: begin
                if (!sel_req) begin
                    ack0_nxt = 1'b0;
                    ack1_nxt = 1'b0;
                    if (chk_ok) begin
                        sreq_nxt  = 1'b1;
                        state_nxt = ST_OUT_ACK;
                    end else begin
                        prio_nxt  = !sel;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OUT_ACK: begin
                if (snd0_ack) begin
                    sreq_nxt  = 1'b0;
                    state_nxt = ST_OUT_REL;
                end
            end
            ST_OUT_REL: begin
                if (!snd0_ack) begin
                    last_nxt  = sel;
                    prio_nxt  = !sel;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Every output is a flop, so no input reaches an output combinationally.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            sel        <= 1'b0;
            prio       <= 1'b0;
            snd0_dat   <= '0;
            snd0_red   <= '0;
            rcv0_ack   <= 1'b0;
            rcv1_ack   <= 1'b0;
            snd0_req   <= 1'b0;
            o_last_src <= 1'b0;
            rdy_sr     <= 2'b00;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            prio       <= prio_nxt;
            snd0_dat   <= dat_nxt;
            snd0_red   <= red_nxt;
            rcv0_ack   <= ack0_nxt;
            rcv1_ack   <= ack1_nxt;
            snd0_req   <= sreq_nxt;
            o_last_src <= last_nxt;
            rdy_sr     <= {rdy_sr[0], 1'b1};
        end
    end

endmodule
